// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with memory wait timeout.
// Optional jal support is enabled by defining JAL_EN.
module mc_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       gpr_write,
  output logic [1:0] reg_dst,
  output logic       alu_src,
  output logic [2:0] alu_op,
  output logic [1:0] ext_op,
  output logic [1:0] npc_sel,
  output logic [1:0] wb_sel,
  output logic       mem_read,
  output logic       mem_write,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  // 2^CNT_W must exceed MEM_WAIT_MAX so the terminal count is reachable.
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MEM_WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       funct_q, funct_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;

  logic       pc_write_c, ir_write_c, gpr_write_c, alu_src_c, mem_read_c, mem_write_c;
  logic [1:0] reg_dst_c, ext_op_c, npc_sel_c, wb_sel_c;
  logic [2:0] alu_op_c;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: ok = (fn == FN_ADDU) || (fn == FN_SUBU) || (fn == FN_AND) ||
                     (fn == FN_OR) || (fn == FN_SLT);
      OP_J, OP_BEQ, OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW: ok = 1'b1;
`ifdef JAL_EN
      OP_JAL: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
    logic [2:0] op;
    op = ALU_ADD;
    case (fn)
      FN_SUBU: op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      cnt_q     <= '0;
      op_q      <= '0;
      funct_q   <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    op_d        = op_q;
    funct_d     = funct_q;
    illegal_d   = illegal_q;
    bus_err_d   = bus_err_q;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    gpr_write_c = 1'b0;
    reg_dst_c   = 2'd0;
    alu_src_c   = 1'b0;
    alu_op_c    = ALU_ADD;
    ext_op_c    = 2'd0;
    npc_sel_c   = 2'd0;
    wb_sel_c    = 2'd0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read_c = 1'b1;
        // A ready in the terminal-count cycle still wins over the timeout.
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = DECODE;
        end else if (cnt_q == WAIT_MAX) begin
          bus_err_d = 1'b1;
          state_d   = HALT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DECODE: begin
        op_d    = opcode;
        funct_d = funct;
        if (!is_legal(opcode, funct)) begin
          illegal_d = 1'b1;
          state_d   = HALT;
        end else if (opcode == OP_J) begin
          pc_write_c = 1'b1;
          npc_sel_c  = 2'd2;
          state_d    = FETCH;
`ifdef JAL_EN
        end else if (opcode == OP_JAL) begin
          state_d = WB;
`endif
        end else begin
          state_d = EXEC;
        end
      end

      EXEC: begin
        case (op_q)
          OP_RTYPE: begin
            alu_op_c = rtype_alu(funct_q);
            state_d  = WB;
          end
          OP_ADDIU: begin
            alu_src_c = 1'b1;
            ext_op_c  = 2'd1;
            state_d   = WB;
          end
          OP_LW, OP_SW: begin
            alu_src_c = 1'b1;
            ext_op_c  = 2'd1;
            state_d   = MEM;
          end
          OP_ORI: begin
            alu_src_c = 1'b1;
            alu_op_c  = ALU_OR;
            state_d   = WB;
          end
          OP_LUI: begin
            alu_src_c = 1'b1;
            ext_op_c  = 2'd2;
            alu_op_c  = ALU_OR;
            state_d   = WB;
          end
          OP_BEQ: begin
            alu_op_c   = ALU_SUB;
            npc_sel_c  = 2'd1;
            pc_write_c = zero;
            state_d    = FETCH;
          end
          default: state_d = HALT;
        endcase
      end

      MEM: begin
        if (op_q == OP_LW) begin
          mem_read_c = 1'b1;
        end else begin
          mem_write_c = 1'b1;
        end
        if (mem_ready) begin
          state_d = (op_q == OP_LW) ? WB : FETCH;
        end else if (cnt_q == WAIT_MAX) begin
          bus_err_d = 1'b1;
          state_d   = HALT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      WB: begin
        gpr_write_c = 1'b1;
        reg_dst_c   = (op_q == OP_RTYPE) ? 2'd1 : 2'd0;
        wb_sel_c    = (op_q == OP_LW) ? 2'd1 : 2'd0;
`ifdef JAL_EN
        if (op_q == OP_JAL) begin
          reg_dst_c  = 2'd2;
          wb_sel_c   = 2'd2;
          pc_write_c = 1'b1;
          npc_sel_c  = 2'd2;
        end
`endif
        state_d = FETCH;
      end

      // HALT and the unused codes 6/7 absorb until reset.
      default: state_d = state_q;
    endcase

    // Reset gates every output so no strobe escapes while rst_n is low.
    if (!rst_n) begin
      pc_write_c  = 1'b0;
      ir_write_c  = 1'b0;
      gpr_write_c = 1'b0;
      reg_dst_c   = 2'd0;
      alu_src_c   = 1'b0;
      alu_op_c    = ALU_ADD;
      ext_op_c    = 2'd0;
      npc_sel_c   = 2'd0;
      wb_sel_c    = 2'd0;
      mem_read_c  = 1'b0;
      mem_write_c = 1'b0;
    end
  end

  assign pc_write  = pc_write_c;
  assign ir_write  = ir_write_c;
  assign gpr_write = gpr_write_c;
  assign reg_dst   = reg_dst_c;
  assign alu_src   = alu_src_c;
  assign alu_op    = alu_op_c;
  assign ext_op    = ext_op_c;
  assign npc_sel   = npc_sel_c;
  assign wb_sel    = wb_sel_c;
  assign mem_read  = mem_read_c;
  assign mem_write = mem_write_c;
  assign illegal   = illegal_q;
  assign bus_err   = bus_err_q;
  assign state     = state_q;

endmodule
